vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates the raster timing stream that every drawing stage in the VGA pipeline consumes: hcount, vcount, hsync, vsync, hblnk, vblnk.
- It is the source end of the same timing interface that the drawing and overlay stages receive and forward.
- Default mode is 800x600 at 60 Hz with a 40 MHz pclk.
- All outputs are registered and mutually aligned, so downstream stages see a coherent pixel position every cycle.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync (1 = active-high)

Ports:
- pclk  input  1  pixel clock; everything is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; when low, the raster freezes
- hcount_out  output  11  current horizontal position, 0..H_TOTAL-1
- vcount_out  output  11  current vertical position, 0..V_TOTAL-1
- hsync_out  output  1  horizontal sync, polarity set by HSYNC_POL
- vsync_out  output  1  vertical sync, polarity set by VSYNC_POL
- hblnk_out  output  1  high while hcount_out >= H_ACTIVE
- vblnk_out  output  1  high while vcount_out >= V_ACTIVE
- frame_start  output  1  one-cycle pulse in the cycle where (hcount_out, vcount_out) = (0,0)

Behaviour:
- Derived localparams:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628)
- Elaboration check: H_TOTAL and V_TOTAL must both be <= 2048; violation is an elaboration error.
- Reset (rst_n low, asynchronous):
  - hcount_out=0, vcount_out=0
  - hblnk_out=0, vblnk_out=0
  - hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL
  - frame_start=0
- First cycle after reset release with en=1: outputs describe pixel (1,0).
  - Pixel (0,0) is the reset state; frame_start is not asserted for it.
- Counting, on each pclk edge with en=1:
  - If h == H_TOTAL-1: h <= 0.
    - Also, if v == V_TOTAL-1 then v <= 0, else v <= v+1.
  - Otherwise h <= h+1 and v holds.
  - 11-bit unsigned arithmetic; wrap is explicit at the terminal count and never relies on overflow.
- Decode is computed from the next counter values and registered in the same edge, so all outputs have zero skew relative to each other:
  - hblnk = (h_next >= H_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= h_next < H_ACTIVE+H_FP+H_SYNC (default 840..967)
  - vblnk = (v_next >= V_ACTIVE)
  - vsync active when V_ACTIVE+V_FP <= v_next < V_ACTIVE+V_FP+V_SYNC (default 601..604); vsync changes only together with a line wrap
  - frame_start = (h_next==0 && v_next==0)
- en=0:
  - All registers hold, including frame_start; a pulse in progress stretches for the duration of the stall.
  - en is sampled every edge; there is no restart on re-enable.
- Reset mid-frame: outputs immediately take their reset values regardless of en. The next frame is short by design; downstream stages must tolerate this.
- Throughput: one pixel per enabled pclk. Latency from counter to decode outputs is zero extra cycles.

Decomposition:
- Package vga_timing_pkg:
  - default timing localparams for 800x600@60
  - H_TOTAL/V_TOTAL computation
  - COUNT_W = 11
- Same package is shared with the drawing stages.
- Natural sub-module: vga_axis_counter, instanced twice (horizontal and vertical). It holds:
  - a counter with terminal-count wrap and an increment-enable input
  - blank/sync window compare against parameters
- The vertical instance's increment enable is the horizontal terminal count ANDed with en.

Test Plan:
- Reset hold, then release with en=1 -> cycle 1 shows h=1,v=0; hblnk=0, vblnk=0; hsync and vsync inactive.
- Run one line -> hblnk rises when h=800; hsync active for h=840..967 (128 cycles); h wraps 1055->0 with v 0->1 on the same edge.
- Run a full frame, 1056*628 = 663168 cycles -> vblnk high for v=600..627; vsync high exactly 4 lines (v=601..604); frame_start pulses once per frame at (0,0).
- en low for 10 cycles at h=1055 -> counters and outputs frozen. On re-enable, next edge gives h=0 and v+1, with no skipped or duplicated pixel.
- Assert rst_n low asynchronously at h=500, v=300 -> outputs go to reset values before the next pclk edge. Counting resumes from (1,0) after release.
- Instance with HSYNC_POL=0, VSYNC_POL=0 -> sync outputs idle high and pulse low, with the same windows as the default instance.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster definitions: counter width, default 800x600@60 timing
// and the helper that sums an axis into its total period.
package vga_timing_pkg;

    localparam int COUNT_W   = 11;
    localparam int MAX_TOTAL = 2048;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus blank/sync window decode,
// with the decode taken from the next count so it lines up with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               tc_o,
    output logic               blank_o,
    output logic               sync_o
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;
    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);

    logic [COUNT_W-1:0] count_q, count_d;
    logic               blank_q, blank_d;
    logic               sync_q, sync_d;
    logic               tc;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = tc ? '0 : count_q + COUNT_W'(1);
        end
        // Compared as int so a window ending exactly at 2048 cannot overflow.
        blank_d = (int'(count_d) >= ACTIVE);
        sync_d  = ((int'(count_d) >= SYNC_START) && (int'(count_d) < SYNC_END)) ? POL : ~POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= ~POL;
        end else if (inc_i) begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc;
    assign blank_o = blank_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing source: horizontal and vertical axis counters chained by
// the line terminal count, all outputs registered on the same pclk edge.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic               frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
            $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
        end
    endgenerate

    logic h_tc, v_tc, v_inc;
    logic frame_start_q, frame_start_d;

    assign v_inc = h_tc & en;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL)
    ) u_h_axis (
        .clk     (pclk),
        .rst_n   (rst_n),
        .inc_i   (en),
        .count_o (hcount_out),
        .tc_o    (h_tc),
        .blank_o (hblnk_out),
        .sync_o  (hsync_out)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL)
    ) u_v_axis (
        .clk     (pclk),
        .rst_n   (rst_n),
        .inc_i   (v_inc),
        .count_o (vcount_out),
        .tc_o    (v_tc),
        .blank_o (vblnk_out),
        .sync_o  (vsync_out)
    );

    // The next position is (0,0) exactly when both axes sit at terminal count.
    always_comb begin
        frame_start_d = frame_start_q;
        if (en) begin
            frame_start_d = h_tc & v_tc;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default, inverted-polarity and small-timing instances
// checked every cycle against a pixel-index model of the raster.
module tb_vga_timing;

    localparam int A_HA = 800, A_HFP = 40, A_HS = 128, A_HBP = 88;
    localparam int A_VA = 600, A_VFP = 1,  A_VS = 4,   A_VBP = 23;
    localparam int C_HA = 16,  C_HFP = 3,  C_HS = 5,   C_HBP = 4;
    localparam int C_VA = 10,  C_VFP = 2,  C_VS = 3,   C_VBP = 2;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    logic [10:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
    logic hs_a, vs_a, hb_a, vb_a, fs_a;
    logic hs_b, vs_b, hb_b, vb_b, fs_b;
    logic hs_c, vs_c, hb_c, vb_c, fs_c;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint pix_a    = 0;
    longint pix_c    = 0;

    always #5 pclk = ~pclk;

    vga_timing dut_a (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(hc_a), .vcount_out(vc_a), .hsync_out(hs_a), .vsync_out(vs_a),
        .hblnk_out(hb_a), .vblnk_out(vb_a), .frame_start(fs_a)
    );

    vga_timing #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(hc_b), .vcount_out(vc_b), .hsync_out(hs_b), .vsync_out(vs_b),
        .hblnk_out(hb_b), .vblnk_out(vb_b), .frame_start(fs_b)
    );

    vga_timing #(
        .H_ACTIVE(C_HA), .H_FP(C_HFP), .H_SYNC(C_HS), .H_BP(C_HBP),
        .V_ACTIVE(C_VA), .V_FP(C_VFP), .V_SYNC(C_VS), .V_BP(C_VBP)
    ) dut_c (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .hcount_out(hc_c), .vcount_out(vc_c), .hsync_out(hs_c), .vsync_out(vs_c),
        .hblnk_out(hb_c), .vblnk_out(vb_c), .frame_start(fs_c)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
        end
    endtask

    // Model: position is just the count of enabled edges since reset.
    task automatic check_raster(input string name, input longint pix,
                                input int ha, input int hfp, input int hs, input int hbp,
                                input int va, input int vfp, input int vs, input int vbp,
                                input bit hpol, input bit vpol,
                                input logic [10:0] hc, input logic [10:0] vc,
                                input logic hsy, input logic vsy,
                                input logic hbl, input logic vbl, input logic fs);
        longint ht, vt, h, v;
        bit     hact, vact, fexp;
        ht   = ha + hfp + hs + hbp;
        vt   = va + vfp + vs + vbp;
        h    = pix % ht;
        v    = (pix / ht) % vt;
        hact = (h >= ha + hfp) && (h < ha + hfp + hs);
        vact = (v >= va + vfp) && (v < va + vfp + vs);
        fexp = (pix > 0) && ((pix % (ht * vt)) == 0);
        check_val({name, ".hcount"}, hc, h);
        check_val({name, ".vcount"}, vc, v);
        check_val({name, ".hblnk"}, hbl, (h >= ha) ? 1 : 0);
        check_val({name, ".vblnk"}, vbl, (v >= va) ? 1 : 0);
        check_val({name, ".hsync"}, hsy, hact ? hpol : !hpol);
        check_val({name, ".vsync"}, vsy, vact ? vpol : !vpol);
        check_val({name, ".frame_start"}, fs, fexp);
    endtask

    task automatic check_all();
        check_raster("a", pix_a, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
                     1'b1, 1'b1, hc_a, vc_a, hs_a, vs_a, hb_a, vb_a, fs_a);
        check_raster("b", pix_a, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
                     1'b0, 1'b0, hc_b, vc_b, hs_b, vs_b, hb_b, vb_b, fs_b);
        check_raster("c", pix_c, C_HA, C_HFP, C_HS, C_HBP, C_VA, C_VFP, C_VS, C_VBP,
                     1'b1, 1'b1, hc_c, vc_c, hs_c, vs_c, hb_c, vb_c, fs_c);
    endtask

    task automatic step();
        @(posedge pclk);
        if (rst_n && en) begin
            pix_a++;
            pix_c++;
        end
        @(negedge pclk);
        check_all();
    endtask

    initial begin
        longint v_exp;
        int n_hs_a, n_hs_b, n_hb_a, n_fs_c, n_vs_c, n_vb_c;

        repeat (3) @(negedge pclk);
        check_all();
        $display("reset hold: checks=%0d", n_checks);

        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check_val("first.hcount", hc_a, 1);
        check_val("first.vcount", vc_a, 0);
        $display("release: a=(%0d,%0d)", hc_a, vc_a);

        for (int i = 0; i < 2500; i++) begin
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        $display("random en: pix_a=%0d pix_c=%0d", pix_a, pix_c);

        en = 1'b1;
        for (int i = 0; i < 1100 && (pix_a % 1056) != 1055; i++) step();
        check_val("seek.h1055", hc_a, 1055);
        v_exp = (pix_a / 1056) % 628;
        en = 1'b0;
        repeat (10) step();
        check_val("stall.hcount", hc_a, 1055);
        check_val("stall.vcount", vc_a, v_exp);
        en = 1'b1;
        step();
        check_val("wrap.hcount", hc_a, 0);
        check_val("wrap.vcount", vc_a, (v_exp + 1) % 628);
        $display("stall at 1055 then wrap: a=(%0d,%0d)", hc_a, vc_a);

        n_hs_a = 0; n_hs_b = 0; n_hb_a = 0; n_fs_c = 0; n_vs_c = 0; n_vb_c = 0;
        for (int i = 0; i < 1056; i++) begin
            step();
            if (hs_a) n_hs_a++;
            if (!hs_b) n_hs_b++;
            if (hb_a) n_hb_a++;
            if (i < 476) begin
                if (fs_c) n_fs_c++;
                if (vs_c) n_vs_c++;
                if (vb_c) n_vb_c++;
            end
        end
        check_val("line.hsync_a_cycles", n_hs_a, 128);
        check_val("line.hsync_b_low_cycles", n_hs_b, 128);
        check_val("line.hblnk_a_cycles", n_hb_a, 256);
        check_val("frame.frame_start_c", n_fs_c, 1);
        check_val("frame.vsync_c_cycles", n_vs_c, C_VS * 28);
        check_val("frame.vblnk_c_cycles", n_vb_c, 7 * 28);
        $display("window counts: hs_a=%0d hs_b=%0d fs_c=%0d vs_c=%0d", n_hs_a, n_hs_b, n_fs_c, n_vs_c);

        for (int i = 0; i < 1100 && (pix_a % 1056) != 500; i++) step();
        check_val("seek.h500", hc_a, 500);
        #2;
        rst_n = 1'b0;
        pix_a = 0;
        pix_c = 0;
        #1;
        check_all();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_val("resume.hcount", hc_a, 1);
        check_val("resume.vcount", vc_a, 0);
        $display("async reset mid-line then resume: a=(%0d,%0d)", hc_a, vc_a);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
